// File: rtl/smm0_strassen_2x2_pkg.sv
// rtl/smm0_strassen_2x2_pkg.sv - shared constants and elementwise helpers for the Strassen 2x2 leaf
package smm0_strassen_2x2_pkg;

   localparam int DW_DEFAULT = 32;
   localparam int BW_DEFAULT = 4 * DW_DEFAULT;
   localparam int NPROD      = 7;

   localparam int E00 = 0;
   localparam int E01 = 1;
   localparam int E10 = 2;
   localparam int E11 = 3;

   // Elementwise wrapping add/sub of two packed 2x2 blocks, for the 4x4 level.
   function automatic logic [BW_DEFAULT-1:0] mat_add(input logic [BW_DEFAULT-1:0] x,
                                                     input logic [BW_DEFAULT-1:0] y);
      logic [BW_DEFAULT-1:0] r;
      r = '0;
      for (int e = 0; e < 4; e++)
         r[e*DW_DEFAULT +: DW_DEFAULT] = x[e*DW_DEFAULT +: DW_DEFAULT] + y[e*DW_DEFAULT +: DW_DEFAULT];
      return r;
   endfunction

   function automatic logic [BW_DEFAULT-1:0] mat_sub(input logic [BW_DEFAULT-1:0] x,
                                                     input logic [BW_DEFAULT-1:0] y);
      logic [BW_DEFAULT-1:0] r;
      r = '0;
      for (int e = 0; e < 4; e++)
         r[e*DW_DEFAULT +: DW_DEFAULT] = x[e*DW_DEFAULT +: DW_DEFAULT] - y[e*DW_DEFAULT +: DW_DEFAULT];
      return r;
   endfunction

endpackage

// File: rtl/smm0_pre_add.sv
// rtl/smm0_pre_add.sv - combinational Strassen T/S operand generator, sel-aware
module smm0_pre_add
   import smm0_strassen_2x2_pkg::*;
#(
   parameter int DATAWIDTH = DW_DEFAULT,
   parameter int BUSWIDTH  = 4 * DATAWIDTH
) (
   input  logic [BUSWIDTH-1:0]          a,
   input  logic [BUSWIDTH-1:0]          b,
   input  logic                         sel,
   output logic [NPROD*DATAWIDTH-1:0]   t,
   output logic [NPROD*DATAWIDTH-1:0]   s
);

   logic [DATAWIDTH-1:0] a00, a01, a10, a11;
   logic [DATAWIDTH-1:0] b00, b01, b10, b11;

   assign a00 = a[E00*DATAWIDTH +: DATAWIDTH];
   assign a01 = a[E01*DATAWIDTH +: DATAWIDTH];
   assign a10 = a[E10*DATAWIDTH +: DATAWIDTH];
   assign a11 = a[E11*DATAWIDTH +: DATAWIDTH];
   assign b00 = b[E00*DATAWIDTH +: DATAWIDTH];
   assign b10 = b[E10*DATAWIDTH +: DATAWIDTH];
   // Vector mode duplicates column 0 so M2..M5 alone yield A x [B00;B10].
   assign b01 = sel ? b00 : b[E01*DATAWIDTH +: DATAWIDTH];
   assign b11 = sel ? b10 : b[E11*DATAWIDTH +: DATAWIDTH];

   always_comb begin
      t = '0;
      s = '0;
      t[1*DATAWIDTH +: DATAWIDTH] = a10 + a11;
      s[1*DATAWIDTH +: DATAWIDTH] = b00;
      t[2*DATAWIDTH +: DATAWIDTH] = a00;
      s[2*DATAWIDTH +: DATAWIDTH] = b01 - b11;
      t[3*DATAWIDTH +: DATAWIDTH] = a11;
      s[3*DATAWIDTH +: DATAWIDTH] = b10 - b00;
      t[4*DATAWIDTH +: DATAWIDTH] = a00 + a01;
      s[4*DATAWIDTH +: DATAWIDTH] = b11;
      if (!sel) begin
         t[0*DATAWIDTH +: DATAWIDTH] = a00 + a11;
         s[0*DATAWIDTH +: DATAWIDTH] = b00 + b11;
         t[5*DATAWIDTH +: DATAWIDTH] = a10 - a00;
         s[5*DATAWIDTH +: DATAWIDTH] = b00 + b01;
         t[6*DATAWIDTH +: DATAWIDTH] = a01 - a11;
         s[6*DATAWIDTH +: DATAWIDTH] = b10 + b11;
      end
   end

endmodule

// File: rtl/smm0_strassen_2x2.sv
// rtl/smm0_strassen_2x2.sv - 3-stage pipelined Strassen 2x2 multiplier with matrix-vector mode
module smm0_strassen_2x2
   import smm0_strassen_2x2_pkg::*;
#(
   parameter int DATAWIDTH = DW_DEFAULT,
   parameter int BUSWIDTH  = 4 * DATAWIDTH
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [BUSWIDTH-1:0] A,
   input  logic [BUSWIDTH-1:0] B,
   input  logic                load,
   input  logic                sel,
   output logic [BUSWIDTH-1:0] C_out
);

   localparam int PW = NPROD * DATAWIDTH;

   logic [PW-1:0] t_d, s_d;
   logic [PW-1:0] t_q, s_q;
   logic [PW-1:0] m_d, m_q;
   logic          v1, v2;
   logic          sel1, sel2;
   logic [BUSWIDTH-1:0] c_d;

   smm0_pre_add #(
      .DATAWIDTH(DATAWIDTH),
      .BUSWIDTH (BUSWIDTH)
   ) u_pre_add (
      .a  (A),
      .b  (B),
      .sel(sel),
      .t  (t_d),
      .s  (s_d)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         t_q  <= '0;
         s_q  <= '0;
         sel1 <= 1'b0;
         v1   <= 1'b0;
      end else begin
         v1 <= load;
         if (load) begin
            t_q  <= t_d;
            s_q  <= s_d;
            sel1 <= sel;
         end
      end
   end

   always_comb begin
      m_d = '0;
      for (int k = 0; k < NPROD; k++)
         m_d[k*DATAWIDTH +: DATAWIDTH] = t_q[k*DATAWIDTH +: DATAWIDTH] * s_q[k*DATAWIDTH +: DATAWIDTH];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         m_q  <= '0;
         sel2 <= 1'b0;
         v2   <= 1'b0;
      end else begin
         v2 <= v1;
         if (v1) begin
            m_q  <= m_d;
            sel2 <= sel1;
         end
      end
   end

   logic [DATAWIDTH-1:0] m1, m2, m3, m4, m5, m6, m7;

   assign m1 = m_q[0*DATAWIDTH +: DATAWIDTH];
   assign m2 = m_q[1*DATAWIDTH +: DATAWIDTH];
   assign m3 = m_q[2*DATAWIDTH +: DATAWIDTH];
   assign m4 = m_q[3*DATAWIDTH +: DATAWIDTH];
   assign m5 = m_q[4*DATAWIDTH +: DATAWIDTH];
   assign m6 = m_q[5*DATAWIDTH +: DATAWIDTH];
   assign m7 = m_q[6*DATAWIDTH +: DATAWIDTH];

   // In vector mode the result column lands in C00/C10; column 1 is zero.
   always_comb begin
      c_d = '0;
      if (sel2) begin
         c_d[E00*DATAWIDTH +: DATAWIDTH] = m3 + m5;
         c_d[E10*DATAWIDTH +: DATAWIDTH] = m2 + m4;
      end else begin
         c_d[E00*DATAWIDTH +: DATAWIDTH] = m1 + m4 - m5 + m7;
         c_d[E01*DATAWIDTH +: DATAWIDTH] = m3 + m5;
         c_d[E10*DATAWIDTH +: DATAWIDTH] = m2 + m4;
         c_d[E11*DATAWIDTH +: DATAWIDTH] = m1 - m2 + m3 + m6;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         C_out <= '0;
      else if (v2)
         C_out <= c_d;
   end

endmodule

// File: tb/tb_smm0_strassen_2x2.sv
// tb/tb_smm0_strassen_2x2.sv - self-checking bench for smm0_strassen_2x2
module tb_smm0_strassen_2x2;

   localparam int DW = 32;
   localparam int BW = 4 * DW;

   logic          clk;
   logic          rst;
   logic [BW-1:0] A, B;
   logic          load, sel;
   logic [BW-1:0] C_out;

   int n_checks = 0;
   int n_fail   = 0;

   // Expected-result pipeline: slot 0 = op sampled at the last edge, slot 1 = one edge older.
   logic          pv [2];
   logic [BW-1:0] pc [2];
   logic [BW-1:0] exp_c;

   smm0_strassen_2x2 #(.DATAWIDTH(DW), .BUSWIDTH(BW)) dut (
      .clk  (clk),
      .rst  (rst),
      .A    (A),
      .B    (B),
      .load (load),
      .sel  (sel),
      .C_out(C_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [BW-1:0] pk(input int e00, input int e01, input int e10, input int e11);
      logic [31:0] x00, x01, x10, x11;
      x00 = e00; x01 = e01; x10 = e10; x11 = e11;
      return {x11, x10, x01, x00};
   endfunction

   // Plain matrix product with 32-bit wrapping int arithmetic.
   function automatic logic [BW-1:0] ref_mul(input logic [BW-1:0] a, input logic [BW-1:0] b, input logic s);
      int x[4];
      int y[4];
      int c[4];
      for (int i = 0; i < 4; i++) begin
         x[i] = a[i*DW +: DW];
         y[i] = b[i*DW +: DW];
      end
      if (s) begin
         c[0] = x[0]*y[0] + x[1]*y[2];
         c[1] = 0;
         c[2] = x[2]*y[0] + x[3]*y[2];
         c[3] = 0;
      end else begin
         c[0] = x[0]*y[0] + x[1]*y[2];
         c[1] = x[0]*y[1] + x[1]*y[3];
         c[2] = x[2]*y[0] + x[3]*y[2];
         c[3] = x[2]*y[1] + x[3]*y[3];
      end
      return pk(c[0], c[1], c[2], c[3]);
   endfunction

   task automatic model_clear();
      pv[0] = 1'b0; pv[1] = 1'b0;
      pc[0] = '0;   pc[1] = '0;
      exp_c = '0;
   endtask

   task automatic check(input string tag, input logic [BW-1:0] expv);
      n_checks++;
      assert (C_out === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, C_out, expv);
      end
   endtask

   task automatic step(input logic ld, input logic [BW-1:0] a, input logic [BW-1:0] b, input logic s);
      @(negedge clk);
      A = a; B = b; load = ld; sel = s;
      @(posedge clk);
      if (pv[1]) exp_c = pc[1];
      pv[1] = pv[0];
      pc[1] = pc[0];
      pv[0] = ld;
      pc[0] = ref_mul(a, b, s);
      #1;
      check("model", exp_c);
   endtask

   task automatic idle();
      step(1'b0, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)));
   endtask

   logic [BW-1:0] a_full, b_full, b_vec, ident;

   initial begin
      a_full = pk(1, 2, 3, 4);
      b_full = pk(5, 6, 7, 8);
      b_vec  = pk(5, 99, 7, 99);
      ident  = pk(1, 0, 0, 1);
      model_clear();
      rst = 1'b1; load = 1'b0; sel = 1'b0; A = '0; B = '0;
      @(posedge clk); #1;
      check("reset_state", '0);
      @(negedge clk); rst = 1'b0;

      // Full mode, then hold with garbage on idle inputs
      step(1'b1, a_full, b_full, 1'b0);
      step(1'b0, '0, '0, 1'b0);
      step(1'b0, '0, '0, 1'b0);
      check("full_mode", pk(19, 22, 43, 50));
      idle(); idle(); idle();
      check("full_hold", pk(19, 22, 43, 50));

      // Vector mode
      step(1'b1, a_full, b_vec, 1'b1);
      idle(); idle();
      check("vector_mode", pk(19, 0, 43, 0));

      // Signed values
      step(1'b1, pk(-1, 2, 3, -4), ident, 1'b0);
      idle(); idle();
      check("signed_1", pk(-1, 2, 3, -4));
      step(1'b1, pk(-2, 0, 0, -3), ident, 1'b0);
      idle(); idle();
      check("signed_2", pk(-2, 0, 0, -3));

      // Wrap-around
      step(1'b1, pk(32'h0001_0000, 0, 0, 0), pk(32'h0001_0000, 0, 0, 0), 1'b0);
      idle(); idle();
      check("wrap_zero", '0);
      step(1'b1, pk(32'h7FFF_FFFF, 0, 0, 0), ident, 1'b0);
      idle(); idle();
      check("wrap_max", pk(32'h7FFF_FFFF, 0, 0, 0));

      // Back-to-back mixed sel
      step(1'b1, a_full, b_full, 1'b0);
      step(1'b1, a_full, b_vec, 1'b1);
      step(1'b1, ident, pk(9, 8, 7, 6), 1'b0);
      check("b2b_op1", pk(19, 22, 43, 50));
      idle();
      check("b2b_op2", pk(19, 0, 43, 0));
      idle();
      check("b2b_op3", pk(9, 8, 7, 6));
      idle();
      check("b2b_hold", pk(9, 8, 7, 6));

      // Reset mid-flight
      step(1'b1, a_full, b_full, 1'b0);
      @(negedge clk);
      load = 1'b0;
      rst = 1'b1;
      #1;
      model_clear();
      check("rst_async", '0);
      @(posedge clk); #1;
      check("rst_held", '0);
      @(negedge clk); rst = 1'b0;
      idle(); idle(); idle(); idle();
      check("rst_no_late", '0);
      step(1'b1, pk(-1, 2, 3, -4), ident, 1'b0);
      idle(); idle();
      check("rst_recover", pk(-1, 2, 3, -4));

      // Randomized traffic against the model
      for (int i = 0; i < 80; i++) begin
         step(1'($urandom_range(0, 1)),
              {$urandom, $urandom, $urandom, $urandom},
              {$urandom, $urandom, $urandom, $urandom},
              1'($urandom_range(0, 1)));
      end
      idle(); idle(); idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
